circuit2_frame_accum: RTL

CIRCUIT2_FRAME_ACCUM -- requirements
Module: circuit2_frame_accum

---
 rtl/circuit2_frame_accum_pkg.sv | 15 +
 rtl/circuit2_accum_lane.sv | 44 ++++
 rtl/circuit2_frame_accum.sv | 112 +++++++++++
 3 files changed

// File: rtl/circuit2_frame_accum_pkg.sv
// Shared types and default sizing for the frame accumulator.
// Holds the FSM state enum and the default WIDTH / FRAME_LEN / ACC_WIDTH values.
// Ports: none (package only).
package circuit2_frame_accum_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_FRAME_LEN = 4;
  localparam int DEF_ACC_WIDTH = 34;

endpackage

// File: rtl/circuit2_accum_lane.sv
// Signed accumulator lane: sign-extends each enabled sample and adds it to a running sum.
// Ports: clk_i/rst_i (async active-high), clr_i zeroes the sum (wins over en_i),
//        en_i adds d_i, acc_o is the registered sum. Latency 1, no backpressure.
module circuit2_accum_lane
  import circuit2_frame_accum_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic                        en_i,
  input  logic signed [WIDTH-1:0]     d_i,
  output logic signed [ACC_WIDTH-1:0] acc_o
);

  logic signed [ACC_WIDTH-1:0] acc_q;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic signed [ACC_WIDTH-1:0] d_ext;

  // ACC_WIDTH > WIDTH is guaranteed by the top-level elaboration check.
  assign d_ext = {{(ACC_WIDTH-WIDTH){d_i[WIDTH-1]}}, d_i};

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + d_ext;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/circuit2_frame_accum.sv
// Frame accumulator: sums x and z, tracks max z and count of x>z over FRAME_LEN samples.
// Ports: Clk, Rst (async active-high); x/z/in_valid/in_ready sample input with flush abort;
//        sum_x/sum_z/max_z/gt_count/out_valid/out_ready result output. Latency 1 after last sample;
//        in_ready drops while a result is pending, results hold until out_valid && out_ready.
module circuit2_frame_accum
  import circuit2_frame_accum_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
  input  logic                               Clk,
  input  logic                               Rst,
  input  logic signed [WIDTH-1:0]            x,
  input  logic signed [WIDTH-1:0]            z,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               flush,
  output logic signed [ACC_WIDTH-1:0]        sum_x,
  output logic signed [ACC_WIDTH-1:0]        sum_z,
  output logic signed [WIDTH-1:0]            max_z,
  output logic [$clog2(FRAME_LEN+1)-1:0]     gt_count,
  output logic                               out_valid,
  input  logic                               out_ready
);

  localparam int CW = $clog2(FRAME_LEN+1);

  if (FRAME_LEN < 2 || FRAME_LEN > 256) begin : g_bad_frame_len
    $error("circuit2_frame_accum: FRAME_LEN must be in 2..256");
  end
  if (ACC_WIDTH < WIDTH + $clog2(FRAME_LEN)) begin : g_bad_acc_width
    $error("circuit2_frame_accum: ACC_WIDTH too small for WIDTH and FRAME_LEN");
  end

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [CW-1:0]           gt_q;
  logic signed [WIDTH-1:0] max_q;

  logic in_accum;
  logic accept;
  logic handshake;
  logic lane_clr;

  assign in_accum  = (state_q == ACCUM);
  // flush takes priority over a same-cycle sample, so the sample is dropped.
  assign accept    = in_accum && in_valid && !flush;
  assign handshake = (state_q == DONE) && out_ready;
  assign lane_clr  = (in_accum && flush) || handshake;

  circuit2_accum_lane #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane_x (
    .clk_i (Clk),
    .rst_i (Rst),
    .clr_i (lane_clr),
    .en_i  (accept),
    .d_i   (x),
    .acc_o (sum_x)
  );

  circuit2_accum_lane #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_lane_z (
    .clk_i (Clk),
    .rst_i (Rst),
    .clr_i (lane_clr),
    .en_i  (accept),
    .d_i   (z),
    .acc_o (sum_z)
  );

  // max_z is not cleared between frames: the first sample of each frame reloads it.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      gt_q    <= '0;
      max_q   <= '0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (flush) begin
            cnt_q <= '0;
            gt_q  <= '0;
          end else if (in_valid) begin
            cnt_q <= cnt_q + CW'(1);
            if (x > z) begin
              gt_q <= gt_q + CW'(1);
            end
            if (cnt_q == '0 || z > max_q) begin
              max_q <= z;
            end
            if (cnt_q == CW'(FRAME_LEN-1)) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= ACCUM;
            cnt_q   <= '0;
            gt_q    <= '0;
          end
        end
      endcase
    end
  end

  assign in_ready  = in_accum;
  assign out_valid = (state_q == DONE);
  assign max_z     = max_q;
  assign gt_count  = gt_q;

endmodule
